// File: rtl/spi_sram_ctrl.sv
// spi_sram_ctrl: SPI-slave (LSB first) command sequencer driving a 256x8 SRAM.
// Define SPI_BURST_EN for multi-byte bursts with address auto-increment.
module spi_sram_ctrl (
    input  logic       SCK,
    input  logic       RST,
    input  logic       CSn,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] sramAddr,
    output logic [7:0] sramWData,
    input  logic [7:0] sramRData,
    output logic       sramWE
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sh_q, sh_d, tx_q, tx_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rx_byte;
    logic rd_q, rd_d, we_q, we_d, inc_q, inc_d, miso_q, miso_d, last;
    assign rx_byte = {MOSI, sh_q};
    assign last = cnt_q == 3'd7;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 3'd1;
        sh_d = {MOSI, sh_q[6:1]};
        tx_d = tx_q;
        rd_d = rd_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        we_d = 1'b0;
        inc_d = 1'b0;
        miso_d = 1'b0;
        if (CSn) begin
            state_d = IDLE;
            cnt_d = 3'd0;
        end else begin
`ifdef SPI_BURST_EN
            inc_d = we_q;
`endif
            // write increment lands one edge after the strobe drops
            if (inc_q) addr_d = addr_q + 8'd1;
            case (state_q)
                IDLE: state_d = CMD;
                CMD: if (last) begin
                    state_d = (rx_byte == 8'h02 || rx_byte == 8'h03) ? ADDR : IGNORE;
                    rd_d = rx_byte == 8'h03;
                end
                ADDR: if (last) begin
                    addr_d = rx_byte;
                    state_d = rd_q ? RDATA : WDATA;
                end
                WDATA: if (last) begin
                    wdata_d = rx_byte;
                    we_d = 1'b1;
`ifndef SPI_BURST_EN
                    state_d = IGNORE;
`endif
                end
                RDATA: begin
                    miso_d = (cnt_q == 3'd0) ? sramRData[0] : tx_q[0];
                    tx_d = (cnt_q == 3'd0) ? sramRData[7:1] : {1'b0, tx_q[6:1]};
                    if (last) begin
`ifdef SPI_BURST_EN
                        addr_d = addr_q + 8'd1;
`else
                        state_d = IGNORE;
`endif
                    end
                end
                IGNORE: state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge SCK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q <= 3'd0;
            sh_q <= 7'd0;
            tx_q <= 7'd0;
            rd_q <= 1'b0;
            addr_q <= 8'd0;
            wdata_q <= 8'd0;
            we_q <= 1'b0;
            inc_q <= 1'b0;
            miso_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            tx_q <= tx_d;
            rd_q <= rd_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            we_q <= we_d;
            inc_q <= inc_d;
            miso_q <= miso_d;
        end
    end
    assign MISO = miso_q;
    assign sramAddr = addr_q;
    assign sramWData = wdata_q;
    assign sramWE = we_q;
endmodule

// File: tb/tb_spi_sram_ctrl.sv
// tb_spi_sram_ctrl: scoreboard bench for spi_sram_ctrl with a behavioural 256x8 SRAM.
module tb_spi_sram_ctrl;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    logic SCK = 1'b0, RST = 1'b1, CSn = 1'b1, MOSI = 1'b0, rd_valid = 1'b0;
    logic MISO, sramWE;
    logic [7:0] sramAddr, sramWData, sramRData;
    logic [7:0] mem [256];
    logic [15:0] q_wr [$];
    logic q_miso [$];
    logic [15:0] e_wr;
    logic e_bit;
    int n_cmp = 0, n_bad = 0;

    spi_sram_ctrl dut (
        .SCK(SCK), .RST(RST), .CSn(CSn), .MOSI(MOSI), .MISO(MISO),
        .sramAddr(sramAddr), .sramWData(sramWData), .sramRData(sramRData), .sramWE(sramWE)
    );

    always #5 SCK = ~SCK;
    assign sramRData = mem[sramAddr];
    always @(posedge SCK) if (sramWE) mem[sramAddr] = sramWData;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops expected writes on each strobe and expected MISO bits on marked edges
    always @(posedge SCK) begin
        #1;
        if (sramWE) begin
            if (q_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL we_unexpected: got write addr %h data %h, expected none at %0t", sramAddr, sramWData, $time);
            end else begin
                e_wr = q_wr.pop_front();
                chk("we_addr", sramAddr, e_wr[15:8]);
                chk("we_data", sramWData, e_wr[7:0]);
            end
        end
        if (rd_valid) begin
            if (q_miso.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL miso_extra: got %b, expected no bit queued at %0t", MISO, $time);
            end else begin
                e_bit = q_miso.pop_front();
                chk("miso_bit", {7'd0, MISO}, {7'd0, e_bit});
            end
        end
    end

    task automatic send_bits(input logic [7:0] d, input int n, input logic rv);
        for (int i = 0; i < n; i++) begin
            @(negedge SCK);
            CSn = 1'b0;
            MOSI = d[i];
            rd_valid = rv;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic rv);
        send_bits(d, 8, rv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge SCK);
            CSn = 1'b1;
            MOSI = 1'b0;
            rd_valid = 1'b0;
        end
    endtask

    task automatic after_edge;
        @(posedge SCK);
        #1;
    endtask

    task automatic expect_rd(input logic [7:0] d);
        for (int i = 0; i < 8; i++) q_miso.push_back(d[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h3C;
        idle(2);
        after_edge;
        chk("rst_miso", {7'd0, MISO}, 8'h00);
        chk("rst_addr", sramAddr, 8'h00);
        chk("rst_wdata", sramWData, 8'h00);
        chk("rst_we", {7'd0, sramWE}, 8'h00);
        RST = 1'b0;
        // reset in the middle of a write data byte
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        after_edge;
        chk("pre_rst_addr", sramAddr, 8'h10);
        send_bits(8'hA5, 3, 1'b0);
        @(negedge SCK);
        RST = 1'b1;
        after_edge;
        chk("midrst_miso", {7'd0, MISO}, 8'h00);
        chk("midrst_addr", sramAddr, 8'h00);
        chk("midrst_we", {7'd0, sramWE}, 8'h00);
        @(negedge SCK);
        RST = 1'b0;
        CSn = 1'b1;
        idle(2);
        after_edge;
        chk("post_rst_addr", sramAddr, 8'h00);
        // single write
        q_wr.push_back({8'h10, 8'hA5});
        send_byte(8'h02, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'hA5, 1'b0);
        after_edge;
        chk("wr_we_hi", {7'd0, sramWE}, 8'h01);
        send_bits(8'h00, 1, 1'b0);
        after_edge;
        chk("wr_we_lo", {7'd0, sramWE}, 8'h00);
        chk("wr_addr_hold", sramAddr, 8'h10);
        chk("wr_wdata_hold", sramWData, 8'hA5);
        send_bits(8'h00, 1, 1'b0);
        after_edge;
        chk("wr_addr_inc", sramAddr, BURST ? 8'h11 : 8'h10);
        idle(2);
        chk("mem_10", mem[8'h10], 8'hA5);
        // single read of 0x3C from 0x20
        send_byte(8'h03, 1'b0);
        send_byte(8'h20, 1'b0);
        after_edge;
        chk("rd_addr", sramAddr, 8'h20);
        chk("rd_miso_pre", {7'd0, MISO}, 8'h00);
        expect_rd(8'h3C);
        send_byte(8'h00, 1'b1);
        after_edge;
        chk("rd_addr_after", sramAddr, BURST ? 8'h21 : 8'h20);
        idle(1);
        after_edge;
        chk("rd_miso_idle", {7'd0, MISO}, 8'h00);
        // two-byte write starting at 0xFF, wraps in burst mode
        q_wr.push_back({8'hFF, 8'h11});
        if (BURST) q_wr.push_back({8'h00, 8'h22});
        send_byte(8'h02, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(2);
        chk("mem_ff", mem[8'hFF], 8'h11);
        chk("mem_00", mem[8'h00], BURST ? 8'h22 : 8'h00);
        // two-byte read starting at 0xFF
        expect_rd(8'h11);
        expect_rd(BURST ? 8'h22 : 8'h00);
        send_byte(8'h03, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(2);
        // abort after 5 data bits, then CSn rising on the 8th bit
        send_byte(8'h02, 1'b0);
        send_byte(8'h30, 1'b0);
        send_bits(8'hFF, 5, 1'b0);
        idle(2);
        send_byte(8'h02, 1'b0);
        send_byte(8'h40, 1'b0);
        send_bits(8'hFF, 7, 1'b0);
        idle(2);
        chk("mem_30", mem[8'h30], 8'h00);
        chk("mem_40", mem[8'h40], 8'h00);
        // next frame decodes cleanly; CSn rises while the strobe is high
        q_wr.push_back({8'h31, 8'h96});
        send_byte(8'h02, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h96, 1'b0);
        after_edge;
        chk("wr2_we_hi", {7'd0, sramWE}, 8'h01);
        idle(1);
        after_edge;
        chk("wr2_we_lo", {7'd0, sramWE}, 8'h00);
        chk("wr2_addr_hold", sramAddr, 8'h31);
        idle(1);
        chk("mem_31", mem[8'h31], 8'h96);
        // bad command: MISO stays 0, no write, address unchanged
        expect_rd(8'h00);
        expect_rd(8'h00);
        expect_rd(8'h00);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(1);
        after_edge;
        chk("bad_addr", sramAddr, 8'h31);
        idle(3);
        chk("wr_queue_left", 8'(q_wr.size()), 8'h00);
        chk("miso_queue_left", 8'(q_miso.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
